// File: rtl/vend_pkg.sv
// Shared vending definitions: dispense FSM states, item kinds and the
// latched item-count record.
// Optional feature macro: DISPENSE_SENSE_EN (adds the WAIT_DROP state).
package vend_pkg;

  localparam int DIME_W = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_GAP       = 3'd2,
    S_DONE      = 3'd3
`ifdef DISPENSE_SENSE_EN
    , S_WAIT_DROP = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    K_CANDY  = 2'd0,
    K_DIME   = 2'd1,
    K_NICKEL = 2'd2
  } kind_t;

  typedef struct packed {
    logic              candy;
    logic [DIME_W-1:0] dimes;
    logic              nickel;
  } counts_t;

  // True when at least one item is still owed.
  function automatic logic any_items(counts_t c);
    return c.candy | (c.dimes != '0) | c.nickel;
  endfunction

  // Highest-priority kind with a non-zero count: candy, then dimes, then nickel.
  function automatic kind_t first_kind(counts_t c);
    if (c.candy)            return K_CANDY;
    else if (c.dimes != '0) return K_DIME;
    else                    return K_NICKEL;
  endfunction

  // Remove the item that first_kind() selects from the record.
  function automatic counts_t take_first(counts_t c);
    counts_t r;
    r = c;
    if (r.candy)            r.candy  = 1'b0;
    else if (r.dimes != '0) r.dimes  = r.dimes - 1'b1;
    else                    r.nickel = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Dispense interface between the vending FSM (master) and the dispenser
// (slave). Motor outputs and status flags travel on the same bundle.
// Optional feature macro: DISPENSE_SENSE_EN (adds drop_sense).
interface change_dispenser_if;

  logic                      candy_req;
  logic                      nickel_req;
  logic [vend_pkg::DIME_W-1:0] dime_req;
`ifdef DISPENSE_SENSE_EN
  logic                      drop_sense;
`endif
  logic                      candy_motor;
  logic                      dime_motor;
  logic                      nickel_motor;
  logic                      busy;
  logic                      thanks;
  logic                      overrun;
  logic                      fault;

  modport master (
    output candy_req, nickel_req, dime_req,
`ifdef DISPENSE_SENSE_EN
           drop_sense,
`endif
    input  candy_motor, dime_motor, nickel_motor, busy, thanks, overrun, fault
  );

  modport slave (
    input  candy_req, nickel_req, dime_req,
`ifdef DISPENSE_SENSE_EN
           drop_sense,
`endif
    output candy_motor, dime_motor, nickel_motor, busy, thanks, overrun, fault
  );

endinterface

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the pulse, gap and drop-timeout intervals.
// Loading value V makes done rise V cycles later; done stays high at zero.
module dispense_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count down from the loaded value and park at zero.
  // NOTE: flop state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             count <= '0;
    else if (load)         count <= value;
    else if (count != '0)  count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Dispense sequencer: latches a candy/dime/nickel request and pulses one
// motor per item (candy, dimes, nickel) with a gap between items, then
// strobes thanks for one cycle.
// Optional feature macro: DISPENSE_SENSE_EN (drop_sense check with timeout,
// sticky fault; without it the sequencer is open loop and fault is 0).
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_ALL + 1);

  // The timer reports done V cycles after loading V, so each interval loads N-1.
  localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  kind_t           kind;
  counts_t         pend;
  counts_t         req;
  logic            req_event;
  logic            overrun_q;
  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_done;
`ifdef DISPENSE_SENSE_EN
  logic            drop_seen;
  logic            dropped;
  logic            fault_q;

  assign dropped = drop_seen | bus.drop_sense;
`endif

  assign req       = '{candy: bus.candy_req, dimes: bus.dime_req, nickel: bus.nickel_req};
  assign req_event = any_items(req);

  dispense_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // Reload the shared timer on every transition that starts a timed interval.
  // NOTE: defaults come first so no path leaves a signal unassigned (no latch).
  always_comb begin
    timer_load  = 1'b0;
    timer_value = PULSE_LOAD;
    case (state)
      S_IDLE: begin
        if (req_event) timer_load = 1'b1;
      end
      S_PULSE: begin
        if (timer_done) begin
          timer_load  = 1'b1;
`ifdef DISPENSE_SENSE_EN
          timer_value = dropped ? GAP_LOAD : TIMEOUT_LOAD;
`else
          timer_value = GAP_LOAD;
`endif
        end
      end
`ifdef DISPENSE_SENSE_EN
      S_WAIT_DROP: begin
        if (bus.drop_sense) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end
      end
`endif
      S_GAP: begin
        if (timer_done && any_items(pend)) timer_load = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: item selection, state stepping and the sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      kind      <= K_CANDY;
      pend      <= '0;
      overrun_q <= 1'b0;
`ifdef DISPENSE_SENSE_EN
      drop_seen <= 1'b0;
      fault_q   <= 1'b0;
`endif
    end else begin
      // Any request outside IDLE (including the thanks cycle) is dropped.
      if (state != S_IDLE && req_event) overrun_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (req_event) begin
            kind  <= first_kind(req);
            pend  <= take_first(req);
            state <= S_PULSE;
`ifdef DISPENSE_SENSE_EN
            drop_seen <= 1'b0;
`endif
          end
        end
        S_PULSE: begin
`ifdef DISPENSE_SENSE_EN
          if (bus.drop_sense) drop_seen <= 1'b1;
          if (timer_done) state <= dropped ? S_GAP : S_WAIT_DROP;
`else
          if (timer_done) state <= S_GAP;
`endif
        end
`ifdef DISPENSE_SENSE_EN
        S_WAIT_DROP: begin
          if (bus.drop_sense) begin
            state <= S_GAP;
          end else if (timer_done) begin
            // Jammed item: give up on the rest but still release the vending FSM.
            fault_q <= 1'b1;
            pend    <= '0;
            state   <= S_DONE;
          end
        end
`endif
        S_GAP: begin
          if (timer_done) begin
            if (any_items(pend)) begin
              kind  <= first_kind(pend);
              pend  <= take_first(pend);
              state <= S_PULSE;
`ifdef DISPENSE_SENSE_EN
              drop_seen <= 1'b0;
`endif
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of registered state and kind: one motor at most, no glitches.
  assign bus.candy_motor  = (state == S_PULSE) && (kind == K_CANDY);
  assign bus.dime_motor   = (state == S_PULSE) && (kind == K_DIME);
  assign bus.nickel_motor = (state == S_PULSE) && (kind == K_NICKEL);
  assign bus.busy         = (state != S_IDLE);
  assign bus.thanks       = (state == S_DONE);
  assign bus.overrun      = overrun_q;
`ifdef DISPENSE_SENSE_EN
  assign bus.fault        = fault_q;
`else
  assign bus.fault        = 1'b0;
`endif

endmodule
